// File: rtl/updown_counter_arbiter.sv
// Shared signed up/down counter stepped by N_REQ requesters.
// Round-robin grant, one +/-1 step per clock, clamp or wrap at limits.
module updown_counter_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] dir,
  input  logic             clr,
  output logic [N_REQ-1:0] grant,
  output logic [WIDTH-1:0] val,
  output logic             ovf
);

  localparam int PW = $clog2(N_REQ);

  localparam logic [WIDTH-1:0] VMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] VMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    win;
  logic [PW:0]      sum;
  logic [PW-1:0]    idx;
  logic [N_REQ-1:0] elig;
  logic             found;
  logic [N_REQ-1:0] gnt_nxt;
  logic [WIDTH-1:0] val_nxt;
  logic             ovf_nxt;
  logic             up;

  // Last cycle's winner is masked, so a held req steps every other cycle.
  assign elig = req & ~grant;

  always_comb begin
    found = 1'b0;
    win   = ptr;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ))
        sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_nxt = '0;
    if (found)
      gnt_nxt[win] = 1'b1;
  end

  always_comb begin
    if (win == PW'(N_REQ-1))
      ptr_nxt = '0;
    else
      ptr_nxt = win + PW'(1);
  end

  // Only the winner's dir is looked at; other dir bits may be junk.
  assign up = dir[win];

  always_comb begin
    val_nxt = val;
    ovf_nxt = 1'b0;
    if (up) begin
      if (val == VMAX) begin
        ovf_nxt = 1'b1;
        val_nxt = SATURATE ? VMAX : VMIN;
      end else begin
        val_nxt = val + WIDTH'(1);
      end
    end else begin
      if (val == VMIN) begin
        ovf_nxt = 1'b1;
        val_nxt = SATURATE ? VMIN : VMAX;
      end else begin
        val_nxt = val - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      grant <= '0;
      val   <= '0;
      ovf   <= 1'b0;
      ptr   <= '0;
    end else if (found) begin
      grant <= gnt_nxt;
      val   <= val_nxt;
      ovf   <= ovf_nxt;
      ptr   <= ptr_nxt;
    end else begin
      grant <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Bench for updown_counter_arbiter: vector table plus
// hand sequences for wrap/saturate at both limits.
module tb_updown_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] req;
  logic [3:0] dir;
  logic [3:0] grant;
  logic [3:0] val;
  logic       ovf;
  logic [3:0] grant_w;
  logic [3:0] val_w;
  logic       ovf_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter_arbiter #(
    .N_REQ(4), .WIDTH(4), .SATURATE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir),
    .clr(clr), .grant(grant), .val(val), .ovf(ovf)
  );

  updown_counter_arbiter #(
    .N_REQ(4), .WIDTH(4), .SATURATE(1'b0)
  ) dut_w (
    .clk(clk), .rst(rst), .req(req), .dir(dir),
    .clr(clr), .grant(grant_w), .val(val_w),
    .ovf(ovf_w)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] g;
    logic [3:0] v;
    logic       o;
  } vec_t;

  vec_t vt[$];

  function automatic void add(
    input logic r, input logic c,
    input logic [3:0] rq, input logic [3:0] d,
    input logic [3:0] g, input logic [3:0] v,
    input logic o
  );
    vec_t x;
    x.rst = r; x.clr = c; x.req = rq; x.dir = d;
    x.g = g; x.v = v; x.o = o;
    vt.push_back(x);
  endfunction

  task automatic chk(input string nm, input int n,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b",
               nm, n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c,
                       input logic [3:0] rq,
                       input logic [3:0] d);
    @(negedge clk);
    rst = r; clr = c; req = rq; dir = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; dir = '0;

    // reset and idle
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0);
    // single requester 2, other dir bits don't-care
    for (int i = 0; i < 8; i++)
      add(0, 0, 4'b0100, 4'b1101,
          (i % 2 == 0) ? 4'b0100 : 4'b0000,
          4'(i / 2 + 1), 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // all four up: rotate 0..3, saturate at 7
    for (int i = 0; i < 9; i++)
      add(0, 0, 4'b1111, 4'b1111, 4'(1 << (i % 4)),
          (i < 7) ? 4'(i + 1) : 4'd7, i >= 7);
    // all four down to -8, then clamp
    for (int k = 1; k <= 16; k++)
      add(0, 0, 4'b1111, 4'b0000, 4'(1 << (k % 4)),
          (k <= 15) ? 4'(7 - k) : 4'b1000, k == 16);
    add(1, 0, 0, 0, 0, 0, 0);
    // clr mid-stream at val=5
    for (int i = 0; i < 5; i++)
      add(0, 0, 4'b0011, 4'b0011, 4'(1 << (i % 2)),
          4'(i + 1), 0);
    add(0, 1, 4'b0011, 4'b0011, 0, 0, 0);
    add(0, 0, 4'b0011, 4'b0010, 4'b0001, 4'hf, 0);
    add(0, 0, 4'b0011, 4'b0010, 4'b0010, 4'h0, 0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].clr, vt[i].req, vt[i].dir);
      chk("grant", i, grant, vt[i].g);
      chk("val", i, val, vt[i].v);
      chk("ovf", i, {3'b0, ovf}, {3'b0, vt[i].o});
      chk("onehot", i, {3'b0, $onehot0(grant)}, 4'b0001);
    end

    // wrap vs clamp with requester 0 alone
    drive(1, 0, 0, 0);
    chk("w_rst_val", 0, val_w, 4'h0);
    for (int i = 0; i < 13; i++)
      drive(0, 0, 4'b0001, 4'b0001);
    chk("s_at7", 0, val, 4'd7);
    chk("w_at7", 0, val_w, 4'd7);
    chk("w_ovf0", 0, {3'b0, ovf_w}, 4'b0000);
    drive(0, 0, 4'b0001, 4'b0001);
    chk("w_mask", 0, grant_w, 4'b0000);
    drive(0, 0, 4'b0001, 4'b0001);
    chk("s_sat_val", 0, val, 4'd7);
    chk("s_sat_ovf", 0, {3'b0, ovf}, 4'b0001);
    chk("w_wrap_val", 0, val_w, 4'b1000);
    chk("w_wrap_ovf", 0, {3'b0, ovf_w}, 4'b0001);
    chk("w_wrap_g", 0, grant_w, 4'b0001);
    drive(0, 0, 4'b0001, 4'b0000);
    chk("w_ovf_pulse", 0, {3'b0, ovf_w}, 4'b0000);
    chk("w_hold", 0, val_w, 4'b1000);
    drive(0, 0, 4'b0001, 4'b0000);
    chk("s_down_val", 0, val, 4'd6);
    chk("s_down_ovf", 0, {3'b0, ovf}, 4'b0000);
    chk("w_unwrap_val", 0, val_w, 4'd7);
    chk("w_unwrap_ovf", 0, {3'b0, ovf_w}, 4'b0001);

    // rst with requests pending: grant and val cleared
    drive(1, 0, 4'b1111, 4'b1111);
    chk("rst_g", 0, grant, 4'b0000);
    chk("rst_v", 0, val, 4'b0000);
    drive(0, 0, 4'b1010, 4'b1111);
    chk("post_rst_g", 0, grant, 4'b0010);
    chk("post_rst_v", 0, val, 4'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
